// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO and its read-side adapter.
package sync_fifo_pkg;

  // Number of beats the read adapter can hold (head + skid).
  localparam int ADP_BUF_DEPTH = 2;

  // Width of the adapter's occupancy counter (holds 0..2).
  localparam int ADP_CNT_W = 2;

  typedef logic [ADP_CNT_W-1:0] buf_cnt_t;

  // True when one more FIFO read can be issued without overrunning the buffer.
  // The sum is formed at 3 bits; pop implies cnt >= 1, so it cannot underflow.
  function automatic logic adp_credit_ok(input buf_cnt_t cnt, input logic inflight,
                                         input logic pop);
    logic [2:0] committed;
    committed = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    return committed < 3'(ADP_BUF_DEPTH);
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry head/skid output buffer for the FIFO read adapter.
// 'cap' writes cap_data into the next free slot, 'pop' retires head.
module rd_skid_buf
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output buf_cnt_t         buf_cnt
);

  logic [WIDTH-1:0] head_reg, head_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  buf_cnt_t         cnt_reg, cnt_next;

  // Next-state for the buffer: head is always the oldest beat, skid the younger one.
  always_comb begin
    head_next = head_reg;
    skid_next = skid_reg;
    cnt_next  = cnt_reg;
    case ({cap, pop})
      2'b10: begin
        if (cnt_reg == '0) head_next = cap_data;
        else               skid_next = cap_data;
        cnt_next = cnt_reg + 2'd1;
      end
      2'b01: begin
        head_next = skid_reg;
        cnt_next  = cnt_reg - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the new beat lands behind whatever remains.
        if (cnt_reg == 2'd1) begin
          head_next = cap_data;
        end else begin
          head_next = skid_reg;
          skid_next = cap_data;
        end
      end
      default: ;
    endcase
  end

  // Buffer registers; contents are discarded immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg <= '0;
      skid_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      head_reg <= head_next;
      skid_reg <= skid_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign head    = head_reg;
  assign buf_cnt = cnt_reg;

endmodule

// File: rtl/sync_fifo_rd_adapter.sv
// Read-side adapter for sync_fifo: turns rd_en/empty/registered rd_data into a
// valid/ready stream, hiding the one-cycle read latency at full throughput.
module sync_fifo_rd_adapter
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             fifo_rd_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             busy
);

  logic             inflight_reg;
  logic             pop;
  buf_cnt_t         buf_cnt;
  logic [WIDTH-1:0] head;

  assign m_valid = (buf_cnt != '0);
  assign pop     = m_valid && m_ready;

  // A read is issued only if its data is guaranteed a slot when it returns;
  // pop frees a slot in the same cycle so streaming has no bubbles.
  assign fifo_rd_en = !fifo_empty && adp_credit_ok(buf_cnt, inflight_reg, pop);

  // Remember that a read was issued; its data arrives on fifo_rd_data next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_reg <= 1'b0;
    else        inflight_reg <= fifo_rd_en;
  end

  rd_skid_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap      (inflight_reg),
    .cap_data (fifo_rd_data),
    .pop      (pop),
    .head     (head),
    .buf_cnt  (buf_cnt)
  );

  assign m_data = head;
  assign busy   = m_valid || inflight_reg;

endmodule
